// File: rtl/axi_uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver and its FIFO:
// FSM states, data_bits codes, o_tuser bit positions and the clkdiv floor.
package axi_uart_rx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRKWAIT
    } state_t;

    localparam logic [1:0] DB_5 = 2'd0;
    localparam logic [1:0] DB_6 = 2'd1;
    localparam logic [1:0] DB_7 = 2'd2;
    localparam logic [1:0] DB_8 = 2'd3;

    localparam int unsigned TU_PERR = 0;
    localparam int unsigned TU_FERR = 1;
    localparam int unsigned TU_BRK  = 2;

    localparam int unsigned CLKDIV_MIN = 4;
    localparam int unsigned FRAME_W    = 11;

    // Index of the last data bit for a data_bits code (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
        return {1'b0, code} + 3'd4;
    endfunction

endpackage

// File: rtl/axi_uart_rx_cfg_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is dropped
// unless a pop happens in the same cycle, and the drop is flagged for one cycle.
module axi_uart_fifo #(
    parameter int WIDTH = 11,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [SIZE:0]    level,
    output logic             drop
);

    logic [WIDTH-1:0] mem [2**SIZE];
    logic [SIZE:0]    wptr;
    logic [SIZE:0]    rptr;
    logic             rd_ok;
    logic             wr_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[SIZE] != rptr[SIZE]) && (wptr[SIZE-1:0] == rptr[SIZE-1:0]);
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign level   = wptr - rptr;
    assign rd_data = empty ? '0 : mem[rptr[SIZE-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[SIZE-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            drop <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            drop <= wr_en & ~wr_ok;
        end
    end

endmodule

// File: rtl/axi_uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..8 data bits, optional parity, 1/2 stop)
// with majority-filtered sampling, per-frame status and an AXI-Stream FIFO output.
module axi_uart_rx_cfg
    import axi_uart_rx_cfg_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int CLKDIV_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx,
    input  logic [CLKDIV_W-1:0] clkdiv,
    input  logic [1:0]          data_bits,
    input  logic                parity_enable,
    input  logic                parity_type,
    input  logic                stop_bits,
    output logic [7:0]          o_tdata,
    output logic [2:0]          o_tuser,
    output logic                o_tvalid,
    input  logic                o_tready,
    output logic [SIZE:0]       fifo_level,
    output logic                overflow
);

    localparam logic [CLKDIV_W-1:0] DIV_MIN = CLKDIV_W'(CLKDIV_MIN);

    state_t                state, state_nxt;
    logic                  sync1, sync2;
    logic [2:0]            taps;
    logic                  filt, filt_prev;
    logic [2:0]            warm;
    logic                  armed;
    logic [CLKDIV_W-1:0]   div_l, cnt;
    logic [1:0]            db_l;
    logic                  pen_l, ptype_l, stop2_l;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
    logic                  par_bit, perr, ferr, stop0;
    logic                  start_det, at_sample, push, brk_fin, first_stop;
    logic [2:0]            tuser_fin;
    logic [FRAME_W-1:0]    fifo_rd;
    logic                  fifo_empty, fifo_full;

    assign filt      = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
    assign start_det = armed & filt_prev & ~filt;
    assign at_sample = (cnt == (div_l >> 1));

    // armed stays low after reset until the flushed filter has seen an idle line,
    // so a line held low across reset is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            taps      <= '1;
            filt_prev <= 1'b1;
            warm      <= '0;
            armed     <= 1'b0;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            taps      <= {taps[1:0], sync2};
            filt_prev <= filt;
            if (warm != 3'd5) warm <= warm + 1'b1;
            else if (filt)    armed <= 1'b1;
        end
    end

    always_comb begin
        first_stop          = (bit_idx == 3'd0) ? filt : stop0;
        brk_fin             = (shreg == 8'h00) & (~pen_l | ~par_bit) & ~first_stop;
        tuser_fin           = '0;
        tuser_fin[TU_PERR]  = perr;
        tuser_fin[TU_FERR]  = ferr | ~filt | brk_fin;
        tuser_fin[TU_BRK]   = brk_fin;
        push                = (state == ST_STOP) & at_sample & (bit_idx == {2'b00, stop2_l});
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start_det) state_nxt = ST_START;
            ST_START:   if (at_sample) state_nxt = filt ? ST_IDLE : ST_DATA;
            ST_DATA:    if (at_sample && bit_idx == last_bit_idx(db_l))
                            state_nxt = pen_l ? ST_PARITY : ST_STOP;
            ST_PARITY:  if (at_sample) state_nxt = ST_STOP;
            ST_STOP:    if (push) state_nxt = brk_fin ? ST_BRKWAIT : ST_IDLE;
            ST_BRKWAIT: if (filt) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_l   <= DIV_MIN;
            db_l    <= '0;
            pen_l   <= 1'b0;
            ptype_l <= 1'b0;
            stop2_l <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            stop0   <= 1'b1;
        end else if (state == ST_IDLE) begin
            if (start_det) begin
                div_l   <= (clkdiv < DIV_MIN) ? DIV_MIN : clkdiv;
                db_l    <= data_bits;
                pen_l   <= parity_enable;
                ptype_l <= parity_type;
                stop2_l <= stop_bits;
                cnt     <= '0;
                bit_idx <= '0;
                shreg   <= '0;
                par_bit <= 1'b0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
                stop0   <= 1'b1;
            end
        end else if (state != ST_BRKWAIT) begin
            cnt <= (cnt == div_l - 1'b1) ? '0 : cnt + 1'b1;
            if (at_sample) begin
                case (state)
                    ST_DATA: begin
                        shreg[bit_idx] <= filt;
                        bit_idx        <= (bit_idx == last_bit_idx(db_l)) ? 3'd0 : bit_idx + 1'b1;
                    end
                    ST_PARITY: begin
                        par_bit <= filt;
                        perr    <= ((^shreg) ^ filt) != ptype_l;
                    end
                    ST_STOP: begin
                        if (!filt)            ferr  <= 1'b1;
                        if (bit_idx == 3'd0)  stop0 <= filt;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    axi_uart_fifo #(
        .WIDTH(FRAME_W),
        .SIZE (SIZE)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (push),
        .wr_data({tuser_fin, shreg}),
        .rd_en  (o_tready),
        .rd_data(fifo_rd),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level),
        .drop   (overflow)
    );

    assign o_tvalid = ~fifo_empty;
    assign o_tdata  = fifo_rd[7:0];
    assign o_tuser  = fifo_rd[10:8];

endmodule

// File: tb/tb_axi_uart_rx_cfg.sv
// Scoreboard bench for axi_uart_rx_cfg: frames are serialised onto rx, expected
// {tuser,data} words are queued at send time and compared on each AXI handshake.
`timescale 1ns/1ps
module tb_axi_uart_rx_cfg;

    localparam int SIZE     = 2;
    localparam int CLKDIV_W = 16;

    logic                clk;
    logic                rst_n;
    logic                rx;
    logic [CLKDIV_W-1:0] clkdiv;
    logic [1:0]          data_bits;
    logic                parity_enable;
    logic                parity_type;
    logic                stop_bits;
    logic [7:0]          o_tdata;
    logic [2:0]          o_tuser;
    logic                o_tvalid;
    logic                o_tready;
    logic [SIZE:0]       fifo_level;
    logic                overflow;

    axi_uart_rx_cfg #(
        .SIZE    (SIZE),
        .CLKDIV_W(CLKDIV_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .clkdiv       (clkdiv),
        .data_bits    (data_bits),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .o_tdata      (o_tdata),
        .o_tuser      (o_tuser),
        .o_tvalid     (o_tvalid),
        .o_tready     (o_tready),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #125 clk = ~clk;

    int          total    = 0;
    int          bad      = 0;
    int          ovf_cnt  = 0;
    int          bit_clks = 32;
    logic [10:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (overflow) ovf_cnt++;
            if (o_tvalid && o_tready) begin
                if (sb_q.size() == 0) chk("extra_frame", {21'h0, o_tuser, o_tdata}, 32'hFFFF_FFFF);
                else                  chk("frame", {21'h0, o_tuser, o_tdata}, {21'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit ptype,
                              input bit stop2, input bit flip, input bit stop_low, input bit exp_push);
        logic [7:0] dm;
        logic [7:0] mask;
        bit         par;
        mask          = 8'((1 << nb) - 1);
        dm            = d & mask;
        par           = (^dm) ^ ptype ^ flip;
        data_bits     = 2'(nb - 5);
        parity_enable = pen;
        parity_type   = ptype;
        stop_bits     = stop2;
        if (exp_push) sb_q.push_back({1'b0, stop_low, pen & flip, dm});
        rx = 1'b0;
        tick(bit_clks);
        for (int i = 0; i < nb; i++) begin
            rx = dm[i];
            tick(bit_clks);
        end
        if (pen) begin
            rx = par;
            tick(bit_clks);
        end
        rx = ~stop_low;
        tick(bit_clks);
        rx = 1'b1;
        if (stop2 || stop_low) tick(bit_clks);
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || o_tvalid) && n < maxc) begin
            tick(1);
            n++;
        end
        chk({tag, "_pending"}, sb_q.size(), 0);
        chk({tag, "_tvalid"}, {31'h0, o_tvalid}, 0);
    endtask

    initial begin
        logic [7:0] t1_bytes [4];
        int         glitch_w [3];
        t1_bytes = '{8'h55, 8'hA7, 8'h00, 8'hFF};
        glitch_w = '{1, 3, 10};

        rx = 1'b1; rst_n = 1'b0; o_tready = 1'b1; clkdiv = 16'd32;
        data_bits = 2'd3; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;
        tick(4);
        chk("rst_tvalid", {31'h0, o_tvalid}, 0);
        chk("rst_tdata", {24'h0, o_tdata}, 0);
        chk("rst_tuser", {29'h0, o_tuser}, 0);
        chk("rst_level", {29'h0, fifo_level}, 0);
        chk("rst_ovf", {31'h0, overflow}, 0);
        rst_n = 1'b1;
        tick(2 * bit_clks);

        // 8N1 back-to-back
        foreach (t1_bytes[i]) send_frame(t1_bytes[i], 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("t1", 2000);

        // 7E2 and 5O1, good then flipped parity
        send_frame(8'h2B, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h15, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h2B, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h15, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain("t2", 2000);

        // framing error, then a break on 8O1
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        data_bits = 2'd3; parity_enable = 1'b1; parity_type = 1'b1; stop_bits = 1'b0;
        sb_q.push_back({3'b111, 8'h00});
        rx = 1'b0;
        tick(12 * bit_clks);
        rx = 1'b1;
        tick(2 * bit_clks);
        wait_drain("t3", 2000);

        // glitches shorter than half a bit must not produce frames
        parity_enable = 1'b0;
        foreach (glitch_w[i]) begin
            rx = 1'b0;
            tick(glitch_w[i]);
            rx = 1'b1;
            tick(3 * bit_clks);
            chk("glitch_tvalid", {31'h0, o_tvalid}, 0);
            chk("glitch_level", {29'h0, fifo_level}, 0);
        end
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("t4", 2000);

        // overflow with a depth-4 FIFO
        o_tready = 1'b0;
        ovf_cnt  = 0;
        for (int i = 1; i <= 6; i++) send_frame(8'(i * 8'h11), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i <= 4);
        tick(8);
        chk("t5_level", {29'h0, fifo_level}, 4);
        chk("t5_ovf_pulses", ovf_cnt, 2);
        chk("t5_head", {24'h0, o_tdata}, 32'h11);
        o_tready = 1'b1;
        wait_drain("t5", 2000);
        chk("t5_level_after", {29'h0, fifo_level}, 0);

        // reset in the middle of a frame with a stored word pending
        o_tready = 1'b0;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(2);
        chk("t6_pre_level", {29'h0, fifo_level}, 1);
        rx = 1'b0; tick(bit_clks);
        rx = 1'b1; tick(bit_clks);
        rx = 1'b0; tick(bit_clks / 2);
        rst_n = 1'b0;
        sb_q.delete();
        tick(3);
        chk("t6_rst_tvalid", {31'h0, o_tvalid}, 0);
        chk("t6_rst_tdata", {24'h0, o_tdata}, 0);
        chk("t6_rst_tuser", {29'h0, o_tuser}, 0);
        chk("t6_rst_level", {29'h0, fifo_level}, 0);
        chk("t6_rst_ovf", {31'h0, overflow}, 0);
        rst_n = 1'b1;
        tick(3 * bit_clks);
        rx = 1'b1;
        tick(2 * bit_clks);
        chk("t6_lowline_level", {29'h0, fifo_level}, 0);
        o_tready = 1'b1;
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("t6a", 2000);

        // clkdiv below the floor runs at 4 clocks per bit
        clkdiv   = 16'd2;
        bit_clks = 4;
        tick(4 * bit_clks);
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hBD, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("t6b", 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
